// File: rtl/uart_pkg.sv
// Shared definitions for the demod UART receive path: FSM encodings and bit-timing helpers.
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } bit_state_e;

    typedef enum logic {
        WAIT_HI,
        WAIT_LO
    } pair_state_e;

    function automatic int cycles_per_bit(input int clk_hz, input int bit_rate);
        return clk_hz / bit_rate;
    endfunction

    function automatic int half_bit(input int clk_hz, input int bit_rate);
        return cycles_per_bit(clk_hz, bit_rate) / 2;
    endfunction

endpackage

// File: rtl/uart_rx.sv
// 8N1 UART byte receiver: two-flop synchroniser, mid-bit sampling FSM and LSB-first shift register.
// byte_valid/frame_err are registered one cycle after the stop-bit sample; optional rx_idle with DEMOD_RX_TIMEOUT_EN.
module uart_rx
    import uart_pkg::*;
#(
    parameter int CLK_HZ       = 100000000,
    parameter int BIT_RATE     = 115200,
    parameter int PAYLOAD_BITS = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    rxd,
    output logic                    byte_valid,
    output logic [PAYLOAD_BITS-1:0] byte_data,
    output logic                    frame_err,
    output logic                    busy
`ifdef DEMOD_RX_TIMEOUT_EN
    ,
    output logic                    rx_idle
`endif
);

    localparam int CPB = cycles_per_bit(CLK_HZ, BIT_RATE);
    localparam int HALF = half_bit(CLK_HZ, BIT_RATE);
    localparam int CW = $clog2(CPB + 1);
    localparam int IW = $clog2(PAYLOAD_BITS);
    localparam logic [CW-1:0] CPB_LAST = CW'(CPB - 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(HALF - 1);
    localparam logic [IW-1:0] IDX_LAST = IW'(PAYLOAD_BITS - 1);

    logic                    sync1_q;
    logic                    rxd_s_q;
    bit_state_e              state_q;
    logic [CW-1:0]           cnt_q;
    logic [IW-1:0]           bit_idx_q;
    logic [PAYLOAD_BITS-1:0] shift_q;
    logic                    byte_valid_q;
    logic                    frame_err_q;
    logic                    busy_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q      <= 1'b1;
            rxd_s_q      <= 1'b1;
            state_q      <= IDLE;
            cnt_q        <= '0;
            bit_idx_q    <= '0;
            shift_q      <= '0;
            byte_valid_q <= 1'b0;
            frame_err_q  <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            sync1_q      <= rxd;
            rxd_s_q      <= sync1_q;
            byte_valid_q <= 1'b0;
            frame_err_q  <= 1'b0;
            cnt_q        <= cnt_q + CW'(1);
            case (state_q)
                IDLE: begin
                    cnt_q <= '0;
                    if (!rxd_s_q) state_q <= START;
                end
                START: begin
                    if (cnt_q == HALF_LAST) begin
                        cnt_q <= '0;
                        // busy only asserts once the start bit is confirmed, so glitches never show
                        if (!rxd_s_q) begin
                            state_q   <= DATA;
                            busy_q    <= 1'b1;
                            bit_idx_q <= '0;
                        end else begin
                            state_q <= IDLE;
                        end
                    end
                end
                DATA: begin
                    if (cnt_q == CPB_LAST) begin
                        cnt_q     <= '0;
                        shift_q   <= {rxd_s_q, shift_q[PAYLOAD_BITS-1:1]};
                        bit_idx_q <= bit_idx_q + IW'(1);
                        if (bit_idx_q == IDX_LAST) state_q <= STOP;
                    end
                end
                STOP: begin
                    if (cnt_q == CPB_LAST) begin
                        state_q      <= IDLE;
                        busy_q       <= 1'b0;
                        byte_valid_q <= rxd_s_q;
                        frame_err_q  <= !rxd_s_q;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign byte_valid = byte_valid_q;
    assign byte_data  = shift_q;
    assign frame_err  = frame_err_q;
    assign busy       = busy_q;
`ifdef DEMOD_RX_TIMEOUT_EN
    assign rx_idle    = (state_q == IDLE);
`endif

endmodule

// File: rtl/uart_rx_demod.sv
// Reassembles {hi, lo} UART byte pairs into 12-bit demod samples; demod_valid/sync_err two cycles after the stop sample.
// Optional WAIT_LO idle timeout with resync when DEMOD_RX_TIMEOUT_EN is defined.
module uart_rx_demod
    import uart_pkg::*;
#(
    parameter int CLK_HZ            = 100000000,
    parameter int BIT_RATE          = 115200,
    parameter int PAYLOAD_BITS      = 8
`ifdef DEMOD_RX_TIMEOUT_EN
    ,
    parameter int IDLE_TIMEOUT_BITS = 20
`endif
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        uart_rxd,
    output logic [11:0] demod,
    output logic        demod_valid,
    output logic        frame_err,
    output logic        sync_err,
    output logic        busy
);

    logic                    rx_byte_valid;
    logic [PAYLOAD_BITS-1:0] rx_byte_data;
    logic                    rx_frame_err;
    logic                    rx_busy;

    pair_state_e pair_q;
    logic [3:0]  hi_q;
    logic [11:0] demod_q;
    logic        demod_valid_q;
    logic        sync_err_q;

`ifdef DEMOD_RX_TIMEOUT_EN
    localparam int TO_CYC = IDLE_TIMEOUT_BITS * cycles_per_bit(CLK_HZ, BIT_RATE);
    localparam int TW = $clog2(TO_CYC + 1);
    localparam logic [TW-1:0] TO_LAST = TW'(TO_CYC - 1);

    logic          rx_idle;
    logic [TW-1:0] to_cnt_q;
    logic          to_run;
    logic          to_fire;

    assign to_run  = (pair_q == WAIT_LO) && rx_idle;
    assign to_fire = to_run && (to_cnt_q == TO_LAST);
`endif

    uart_rx #(
        .CLK_HZ       (CLK_HZ),
        .BIT_RATE     (BIT_RATE),
        .PAYLOAD_BITS (PAYLOAD_BITS)
    ) u_rx (
        .clk        (clk),
        .rst        (rst),
        .rxd        (uart_rxd),
        .byte_valid (rx_byte_valid),
        .byte_data  (rx_byte_data),
        .frame_err  (rx_frame_err),
        .busy       (rx_busy)
`ifdef DEMOD_RX_TIMEOUT_EN
        ,
        .rx_idle    (rx_idle)
`endif
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            pair_q        <= WAIT_HI;
            hi_q          <= '0;
            demod_q       <= '0;
            demod_valid_q <= 1'b0;
            sync_err_q    <= 1'b0;
        end else begin
            demod_valid_q <= 1'b0;
            sync_err_q    <= 1'b0;
            // a framing error discards any pending hi nibble silently
            if (rx_frame_err) begin
                pair_q <= WAIT_HI;
            end else if (rx_byte_valid) begin
                case (pair_q)
                    WAIT_HI: begin
                        if (rx_byte_data[7:4] == 4'h0) begin
                            hi_q   <= rx_byte_data[3:0];
                            pair_q <= WAIT_LO;
                        end else begin
                            sync_err_q <= 1'b1;
                        end
                    end
                    WAIT_LO: begin
                        demod_q       <= {hi_q, rx_byte_data[7:0]};
                        demod_valid_q <= 1'b1;
                        pair_q        <= WAIT_HI;
                    end
                    default: pair_q <= WAIT_HI;
                endcase
            end
`ifdef DEMOD_RX_TIMEOUT_EN
            else if (to_fire) begin
                pair_q     <= WAIT_HI;
                sync_err_q <= 1'b1;
            end
`endif
        end
    end

`ifdef DEMOD_RX_TIMEOUT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            to_cnt_q <= '0;
        end else if (to_run && !to_fire) begin
            to_cnt_q <= to_cnt_q + TW'(1);
        end else begin
            to_cnt_q <= '0;
        end
    end
`endif

    assign demod       = demod_q;
    assign demod_valid = demod_valid_q;
    assign frame_err   = rx_frame_err;
    assign sync_err    = sync_err_q;
    assign busy        = rx_busy;

endmodule
